// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Instruction-memory read bus between the fetch unit and instruction memory.
//
// Handshake: the master raises imemReq with imemAddr and holds both steady
// until the slave answers with imemAck=1 for one cycle, at which point
// imemData carries the read word. A request completes on the rising edge
// where imemReq=1 and imemAck=1; imemAck while imemReq=0 carries no meaning.
//
// Signals:
//   imemReq  (master->slave)  read request
//   imemAddr (master->slave)  32-bit word address
//   imemAck  (slave->master)  read data valid this cycle
//   imemData (slave->master)  32-bit read data
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData
  );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetches one instruction at a time from instruction memory, presents it to
// the decoder with a valid/ready handshake, and advances the pc on consume
// (pc+4, or branchTarget when branch&zero).
//
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a taken branch to a non word-aligned target freezes the pc,
//               sets the sticky misaligned flag and parks the FSM in TRAP.
//   undefined : target bits [1:0] are forced to zero, misaligned is tied 0.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   imem             instruction_fetch_if.master (imemReq/imemAddr/imemAck/imemData)
//   instruction      registered fetched instruction (NOP after reset)
//   opcode           instruction[6:0]
//   instrValid       instruction/opcode valid to downstream
//   instrReady       downstream consumes the current instruction
//   branch, zero     taken-branch condition, sampled only on consume
//   branchTarget     taken-branch target, sampled only on consume
//   pc               address of the current instruction
//   misaligned       sticky misaligned-target flag
//   o_dbg_state      current FSM state encoding (IDLE=0 REQ=1 VALID=2 TRAP=3)
//
// Downstream handshake: instrValid=1 holds instruction/pc stable until a
// rising edge with instrReady=1; that edge consumes the instruction.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_if.master        imem,
  output logic [31:0]                instruction,
  output logic [6:0]                 opcode,
  output logic                       instrValid,
  input  logic                       instrReady,
  input  logic                       branch,
  input  logic                       zero,
  input  logic [31:0]                branchTarget,
  output logic [31:0]                pc,
  output logic                       misaligned,
  output logic [1:0]                 o_dbg_state
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_TRAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic        r_misaligned;

  logic        w_consume;
  logic        w_taken;
  logic        w_bad_target;
  logic [31:0] w_target_aligned;
  logic [31:0] w_pc_plus4;

  // Branch inputs only matter on the consume edge.
  assign w_consume        = (r_state == S_VALID) && instrReady;
  assign w_taken          = branch & zero;
  assign w_target_aligned = branchTarget & 32'hFFFF_FFFC;
  assign w_pc_plus4       = r_pc + 32'd4;   // wraps modulo 2^32

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign w_bad_target = w_taken && (branchTarget[1:0] != 2'b00);
`else
  assign w_bad_target = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_REQ;
      S_REQ:   if (imem.imemAck) w_next_state = S_VALID;
      S_VALID: begin
        if (instrReady) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (w_bad_target) w_next_state = S_TRAP;
          else              w_next_state = S_REQ;
`else
          w_next_state = S_REQ;
`endif
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      S_TRAP:  w_next_state = S_TRAP;   // only reset leaves TRAP
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    imem.imemReq = 1'b0;
    instrValid   = 1'b0;
    case (r_state)
      S_REQ:   imem.imemReq = 1'b1;
      S_VALID: instrValid   = 1'b1;
      default: begin
        imem.imemReq = 1'b0;
        instrValid   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: pc, instruction register, sticky misaligned flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instruction <= NOP;
      r_misaligned  <= 1'b0;
    end else begin
      // imemAck outside REQ (IDLE, VALID, TRAP) is deliberately ignored.
      if ((r_state == S_REQ) && imem.imemAck) begin
        r_instruction <= imem.imemData;
      end
      if (w_consume) begin
        if (w_bad_target) begin
          r_misaligned <= 1'b1;          // pc stays on the faulting branch
        end else if (w_taken) begin
          r_pc <= w_target_aligned;
        end else begin
          r_pc <= w_pc_plus4;
        end
      end
    end
  end

  assign imem.imemAddr = r_pc;
  assign pc            = r_pc;
  assign instruction   = r_instruction;
  assign opcode        = r_instruction[6:0];
  assign o_dbg_state   = r_state;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misaligned = r_misaligned;
`else
  // Flag can never set without the trap feature; tie the output low.
  assign misaligned = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imemReq  output  1  instruction-memory read request.
REQ-005 imemAddr  output  32  read address, equals pc.
REQ-006 imemAck  input  1  memory has valid read data this cycle.
REQ-007 imemData  input  32  read data, valid when imemAck=1.
REQ-008 instruction  output  32  registered fetched instruction.
REQ-009 opcode  output  7  instruction[6:0], drives the main control decoder.
REQ-010 instrValid  output  1  instruction/opcode valid for downstream.
REQ-011 instrReady  input  1  downstream consumes the current instruction.
REQ-012 branch  input  1  branch control from the decoder for the current instruction.
REQ-013 zero  input  1  ALU zero flag for the current instruction.
REQ-014 branchTarget  input  32  taken-branch target address.
REQ-015 pc  output  32  address of the current instruction.
REQ-016 misaligned  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, REQ and VALID, plus TRAP when IFETCH_MISALIGN_TRAP_EN is defined.
REQ-018 IDLE SHALL last exactly one cycle, then go to REQ; imemReq=0 and instrValid=0.
REQ-019 In REQ, imemReq SHALL be 1 and imemAddr SHALL equal pc, held stable until imemAck=1.
REQ-020 On imemAck=1 in REQ, instruction SHALL load imemData and the FSM SHALL go to VALID at the same edge; the minimum request-to-instrValid latency is 1 cycle.
REQ-021 imemAck SHALL be ignored in every state other than REQ.
REQ-022 In VALID, instrValid SHALL be 1, imemReq SHALL be 0, and instruction/pc SHALL remain stable until instrReady=1.
REQ-023 On instrReady=1 in VALID, pc SHALL load branchTarget if branch&zero=1, else pc+4, and the FSM SHALL go to REQ.
REQ-024 branch, zero and branchTarget SHALL be sampled only in the VALID&instrReady cycle.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 opcode SHALL be combinationally equal to instruction[6:0] in all states.

Reset
REQ-027 reset=1 SHALL override all other inputs at the edge, from any state including mid-request.
REQ-028 Reset values: state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP), instrValid=0, imemReq=0, misaligned=0.
REQ-029 An imemAck arriving while reset=1 or in the IDLE cycle that follows SHALL be discarded.

Configuration
REQ-030 Macro IFETCH_MISALIGN_TRAP_EN: when defined, a taken branch with branchTarget[1:0]!=2'b00 SHALL leave pc unchanged, set misaligned=1, and enter TRAP.
REQ-031 TRAP SHALL hold imemReq=0 and instrValid=0 until reset; misaligned SHALL stay 1 until reset.
REQ-032 When the macro is undefined, branchTarget[1:0] SHALL be forced to 2'b00 on load, misaligned SHALL be tied 0, and no TRAP state SHALL exist.

Verification
REQ-033 Reset with RESET_PC=32'h100, then ack on the first REQ cycle with data 32'h00A00093 -> imemAddr=32'h100, instrValid=1 the next cycle, opcode=7'b0010011.
REQ-034 Ack delayed by 3 cycles -> imemReq stays 1 and imemAddr stays stable for 4 cycles, instrValid=0 throughout.
REQ-035 In VALID with pc=32'h200: instrReady=1, branch=1, zero=1, target=32'h180 -> next imemAddr=32'h180; with zero=0 -> 32'h204.
REQ-036 instrReady=0 held for 5 cycles in VALID -> instruction, pc and instrValid=1 are unchanged, and no imemReq is issued.
REQ-037 pc=32'hFFFF_FFFC, not-taken consume -> next pc=32'h0000_0000; assert reset during REQ -> IDLE next cycle, and an ack in that cycle is ignored.
REQ-038 With the macro defined, taken branch to 32'h202 -> misaligned=1, pc unchanged, imemReq=0 until reset; with the macro undefined -> pc=32'h200.
